// File: rtl/vec_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vec_accumulator_pkg
// Description : Shared defaults, lane-slice macro and state encoding for the
//               lane-wise signed vector accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package vec_accumulator_pkg;

    localparam int unsigned C_DEF_WIDTH  = 256;
    localparam int unsigned C_DEF_LANE_W = 8;
    localparam int unsigned C_DEF_ACC_W  = 20;
    localparam int unsigned C_DEF_CNT_W  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

endpackage

`define VA_SLICE(IDX, W) (IDX)*(W) +: (W)

`default_nettype wire

// File: rtl/vec_accumulator_sat_add_lane.sv
`default_nettype none
// ============================================================================
// Module      : sat_add_lane
// Description : One lane: sign-extended LANE_W addend plus ACC_W accumulator,
//               clamped to the ACC_W signed range with a saturation flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_add_lane
    import vec_accumulator_pkg::*;
#(
    parameter int LANE_W = C_DEF_LANE_W,
    parameter int ACC_W  = C_DEF_ACC_W
) (
    input  logic [LANE_W-1:0] lane_i,
    input  logic [ACC_W-1:0]  acc_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              sat_o
);

    localparam logic [ACC_W-1:0] C_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] C_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] w_sum;

    // One guard bit: overflow shows as disagreement between the top two bits.
    assign w_sum = {acc_i[ACC_W-1], acc_i}
                 + {{(ACC_W+1-LANE_W){lane_i[LANE_W-1]}}, lane_i};

    assign sat_o = w_sum[ACC_W] ^ w_sum[ACC_W-1];
    assign sum_o = sat_o ? (w_sum[ACC_W] ? C_MIN : C_MAX) : w_sum[ACC_W-1:0];

endmodule

`default_nettype wire

// File: rtl/vec_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : vec_accumulator
// Description : Per-lane saturating burst accumulator with a held result
//               register behind a valid/ready handshake; never stalls input.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_accumulator
    import vec_accumulator_pkg::*;
#(
    parameter int WIDTH  = C_DEF_WIDTH,
    parameter int LANE_W = C_DEF_LANE_W,
    parameter int ACC_W  = C_DEF_ACC_W,
    parameter int CNT_W  = C_DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic [WIDTH-1:0]         dat_in,
    input  logic                     dat_in_vld,
    input  logic                     dat_in_done,
    output logic [WIDTH/LANE_W*ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0]         acc_cnt,
    output logic                     acc_out_vld,
    input  logic                     acc_out_rdy,
    output logic                     busy,
    output logic                     sat,
    output logic                     err_ovr
);

    localparam int LANES = WIDTH / LANE_W;
    localparam int AW    = LANES * ACC_W;

    state_t             state_q, state_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]      out_q, out_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic               out_vld_q, out_vld_d;
    logic               sat_q, sat_d;
    logic               ovr_q, ovr_d;

    logic [AW-1:0]      w_sum;
    logic [LANES-1:0]   w_lane_sat;
    logic [CNT_W-1:0]   w_cnt_inc;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sat_add_lane #(
            .LANE_W (LANE_W),
            .ACC_W  (ACC_W)
        ) u_lane (
            .lane_i (dat_in[`VA_SLICE(i, LANE_W)]),
            .acc_i  (acc_q[`VA_SLICE(i, ACC_W)]),
            .sum_o  (w_sum[`VA_SLICE(i, ACC_W)]),
            .sat_o  (w_lane_sat[i])
        );
    end

    assign w_cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        out_d     = out_q;
        out_cnt_d = out_cnt_q;
        out_vld_d = out_vld_q & ~acc_out_rdy;
        sat_d     = sat_q;
        ovr_d     = ovr_q;

        if (clr) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
            ovr_d   = 1'b0;
        end else if (dat_in_vld) begin
            sat_d = sat_q | (|w_lane_sat);
            if (dat_in_done) begin
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
                // A result still waiting on the consumer wins; the new one is dropped.
                if (!out_vld_q || acc_out_rdy) begin
                    out_d     = w_sum;
                    out_cnt_d = w_cnt_inc;
                    out_vld_d = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end else begin
                state_d = ACC;
                acc_d   = w_sum;
                cnt_d   = w_cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            out_cnt_q <= '0;
            out_vld_q <= 1'b0;
            sat_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            out_q     <= out_d;
            out_cnt_q <= out_cnt_d;
            out_vld_q <= out_vld_d;
            sat_q     <= sat_d;
            ovr_q     <= ovr_d;
        end
    end

    assign acc_out     = out_q;
    assign acc_cnt     = out_cnt_q;
    assign acc_out_vld = out_vld_q;
    assign busy        = (state_q == ACC);
    assign sat         = sat_q;
    assign err_ovr     = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_vec_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_vec_accumulator
// Description : Directed and random stimulus for vec_accumulator against an
//               integer-arithmetic reference model of the burst rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_accumulator;

    localparam int WIDTH  = 256;
    localparam int LANE_W = 8;
    localparam int ACC_W  = 20;
    localparam int CNT_W  = 8;
    localparam int LANES  = WIDTH / LANE_W;
    localparam int AW     = LANES * ACC_W;
    localparam int AMAX   = (1 << (ACC_W-1)) - 1;
    localparam int AMIN   = -(1 << (ACC_W-1));
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clr = 1'b0;
    logic [WIDTH-1:0] dat_in = '0;
    logic             dat_in_vld = 1'b0;
    logic             dat_in_done = 1'b0;
    logic             acc_out_rdy = 1'b0;
    logic [AW-1:0]    acc_out;
    logic [CNT_W-1:0] acc_cnt;
    logic             acc_out_vld, busy, sat, err_ovr;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int acc_m[LANES];
    int out_m[LANES];
    int cnt_m, out_cnt_m;
    bit out_vld_m, busy_m, sat_m, ovr_m;

    vec_accumulator #(
        .WIDTH (WIDTH), .LANE_W (LANE_W), .ACC_W (ACC_W), .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .dat_in      (dat_in),
        .dat_in_vld  (dat_in_vld),
        .dat_in_done (dat_in_done),
        .acc_out     (acc_out),
        .acc_cnt     (acc_cnt),
        .acc_out_vld (acc_out_vld),
        .acc_out_rdy (acc_out_rdy),
        .busy        (busy),
        .sat         (sat),
        .err_ovr     (err_ovr)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < LANES; i++) begin
            acc_m[i] = 0;
            out_m[i] = 0;
        end
        cnt_m = 0; out_cnt_m = 0;
        out_vld_m = 0; busy_m = 0; sat_m = 0; ovr_m = 0;
    endtask

    task automatic model_edge();
        bit nv;
        int s[LANES];
        int lane;
        nv = out_vld_m && !acc_out_rdy;
        if (clr) begin
            for (int i = 0; i < LANES; i++) acc_m[i] = 0;
            cnt_m = 0; busy_m = 0; sat_m = 0; ovr_m = 0;
        end else if (dat_in_vld) begin
            for (int i = 0; i < LANES; i++) begin
                lane = $signed(dat_in[i*LANE_W +: LANE_W]);
                s[i] = acc_m[i] + lane;
                if (s[i] > AMAX) begin s[i] = AMAX; sat_m = 1; end
                if (s[i] < AMIN) begin s[i] = AMIN; sat_m = 1; end
            end
            if (dat_in_done) begin
                if (!out_vld_m || acc_out_rdy) begin
                    for (int i = 0; i < LANES; i++) out_m[i] = s[i];
                    out_cnt_m = (cnt_m + 1 > CMAX) ? CMAX : cnt_m + 1;
                    nv = 1;
                end else begin
                    ovr_m = 1;
                end
                for (int i = 0; i < LANES; i++) acc_m[i] = 0;
                cnt_m = 0; busy_m = 0;
            end else begin
                for (int i = 0; i < LANES; i++) acc_m[i] = s[i];
                cnt_m = (cnt_m + 1 > CMAX) ? CMAX : cnt_m + 1;
                busy_m = 1;
            end
        end
        out_vld_m = nv;
    endtask

    task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [AW-1:0] e;
        logic [31:0]   t;
        for (int i = 0; i < LANES; i++) begin
            t = out_m[i];
            e[i*ACC_W +: ACC_W] = t[ACC_W-1:0];
        end
        chk({tag, ".acc_out"}, acc_out, e);
        chk({tag, ".acc_cnt"}, AW'(acc_cnt), AW'(out_cnt_m));
        chk({tag, ".vld"},     AW'(acc_out_vld), AW'(out_vld_m));
        chk({tag, ".busy"},    AW'(busy), AW'(busy_m));
        chk({tag, ".sat"},     AW'(sat), AW'(sat_m));
        chk({tag, ".err_ovr"}, AW'(err_ovr), AW'(ovr_m));
    endtask

    task automatic step(input string tag, input logic v, input logic d, input logic c,
                        input logic r, input logic [WIDTH-1:0] data);
        dat_in_vld = v; dat_in_done = d; clr = c; acc_out_rdy = r; dat_in = data;
        @(posedge clk);
        if (rst_n) model_edge();
        else model_reset();
        #1;
        check_all(tag);
    endtask

    function automatic logic [WIDTH-1:0] fill(input logic [LANE_W-1:0] v);
        logic [WIDTH-1:0] w;
        for (int i = 0; i < LANES; i++) w[i*LANE_W +: LANE_W] = v;
        return w;
    endfunction

    function automatic logic [WIDTH-1:0] lane0(input logic [LANE_W-1:0] v);
        logic [WIDTH-1:0] w;
        w = '0;
        w[LANE_W-1:0] = v;
        return w;
    endfunction

    function automatic logic [WIDTH-1:0] rnd_word();
        logic [WIDTH-1:0] w;
        for (int i = 0; i < WIDTH/32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    initial begin
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // single-word burst of 5s
        step("single",      1, 1, 0, 1, fill(8'h05));
        step("single_drop", 0, 0, 0, 1, '0);

        // 4-word burst on lane 0
        step("b4_w0", 1, 0, 0, 1, lane0(8'd3));
        step("b4_w1", 1, 0, 0, 1, lane0(8'hFF));
        step("b4_w2", 1, 0, 0, 1, lane0(8'd127));
        step("b4_w3", 1, 1, 0, 1, lane0(8'h80));
        step("b4_idle", 0, 0, 0, 1, '0);

        // back-to-back bursts with the consumer always ready
        step("bb_a0", 1, 0, 0, 1, fill(8'd10));
        step("bb_a1", 1, 1, 0, 1, fill(8'd10));
        step("bb_b0", 1, 0, 0, 1, fill(8'd2));
        step("bb_b1", 1, 1, 0, 1, fill(8'hFE));
        step("bb_c0", 1, 1, 0, 1, fill(8'd7));
        step("bb_end", 0, 0, 0, 1, '0);

        // overrun: consumer stalled while a second result arrives
        step("ov_a", 1, 1, 0, 0, fill(8'd4));
        step("ov_b0", 1, 0, 0, 0, fill(8'd9));
        step("ov_b1", 1, 1, 0, 0, fill(8'd9));
        step("ov_hold", 0, 0, 0, 0, '0);
        step("ov_xfer", 0, 0, 0, 1, '0);
        step("ov_after", 0, 0, 0, 1, '0);
        step("ov_clr", 0, 0, 1, 1, '0);
        step("done_no_vld", 0, 1, 0, 1, fill(8'd1));

        // long saturating burst, result held by a stalled consumer
        for (int k = 0; k < 8999; k++) step("satrun", 1, 0, 0, 0, fill(8'd127));
        step("sat_done", 1, 1, 0, 0, fill(8'd127));
        step("sat_clr", 1, 0, 1, 0, fill(8'd1));
        step("sat_after", 0, 0, 0, 1, '0);
        step("sat_idle", 0, 0, 0, 1, '0);

        // asynchronous reset in the middle of a burst
        step("rst_w0", 1, 0, 0, 1, fill(8'd3));
        step("rst_w1", 1, 0, 0, 1, fill(8'd3));
        step("rst_w2", 1, 0, 0, 1, fill(8'd3));
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("rst_async");
        step("rst_hold", 1, 0, 0, 1, fill(8'd3));
        #2;
        rst_n = 1'b1;
        step("post_w0", 1, 0, 0, 1, fill(8'd1));
        step("post_w1", 1, 1, 0, 1, fill(8'd1));

        // random traffic
        for (int k = 0; k < 600; k++) begin
            logic v, d, c, r;
            logic [WIDTH-1:0] w;
            v = ($urandom_range(0, 3) != 0);
            d = ($urandom_range(0, 4) == 0);
            c = ($urandom_range(0, 40) == 0);
            r = ($urandom_range(0, 9) < 6);
            w = ($urandom_range(0, 3) == 0) ? fill(8'h80) : rnd_word();
            step("rand", v, d, c, r, w);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
